meteor_field: RTL

//  Parametrised multi-meteor generator for the Meteor Dodge VGA game.

---
 rtl/meteor_pkg.sv | 30 +++
 rtl/lfsr16.sv | 23 ++
 rtl/meteor_field.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/meteor_pkg.sv
// meteor_pkg: shared definitions for the meteor field.
//   - per-meteor state encoding (IDLE / FALL)
//   - LFSR seed and Fibonacci tap mask (taps 16,14,13,11)
//   - eff_speed: maps a speed of 0 to 1 row per frame
//   - lfsr_next: one step of the 16-bit Fibonacci LFSR
package meteor_pkg;

  localparam logic [0:0]  ST_IDLE   = 1'b0;
  localparam logic [0:0]  ST_FALL   = 1'b1;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 map to bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [2:0] eff_speed(input logic [2:0] speed);
    logic [2:0] eff;
    if (speed == 3'd0) begin
      eff = 3'd1;
    end else begin
      eff = speed;
    end
    return eff;
  endfunction

  // Shift left, new bit enters at bit 0 as XOR of the tapped bits.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, steps every clock.
// Ports:
//   clock  in   pixel clock
//   reset  in   synchronous, active-high; loads LFSR_SEED
//   value  out  current LFSR state
module lfsr16
  import meteor_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] value
);

  // LFSR state register
  always_ff @(posedge clock) begin
    if (reset) begin
      value <= LFSR_SEED;
    end else begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/meteor_field.sv
// meteor_field: tracks NUM_METEORS falling meteors, spawns them at
// pseudo-random columns, advances them once per enabled frame, renders a
// registered meteor mask, flags player collisions and counts dodges.
// Ports:
//   clock, reset           pixel clock, synchronous active-high reset
//   frame_tick             1-cycle pulse per frame (start of vblank)
//   enable                 1 = motion and spawning run; 0 = frozen
//   speed[2:0]             rows per frame (0 behaves as 1)
//   h_count, v_count       current pixel coordinates
//   player_on              player sprite covers the current pixel
//   hit_clear              clears the sticky hit flag
//   meteor_on              registered meteor mask (1 clock latency)
//   hit                    sticky collision flag
//   dodged                 1-cycle pulse after a frame with an exit
//   dodge_count[7:0]       saturating dodge counter
module meteor_field
  import meteor_pkg::*;
#(
  parameter int NUM_METEORS = 4,
  parameter int COORD_W     = 10,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SIZE        = 16,
  parameter int SPAWN_GAP   = 20
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               enable,
  input  logic [2:0]         speed,
  input  logic [COORD_W-1:0] h_count,
  input  logic [COORD_W-1:0] v_count,
  input  logic               player_on,
  input  logic               hit_clear,
  output logic               meteor_on,
  output logic               hit,
  output logic               dodged,
  output logic [7:0]         dodge_count
);

  localparam int CNT_W = (SPAWN_GAP < 1) ? 1 : $clog2(SPAWN_GAP + 1);
  localparam logic [CNT_W-1:0]   GAP_RELOAD = CNT_W'(SPAWN_GAP);
  localparam logic [COORD_W-1:0] X_SPAN     = COORD_W'(H_ACTIVE - SIZE);
  localparam logic [COORD_W:0]   Y_LIMIT    = (COORD_W + 1)'(V_ACTIVE);
  localparam logic [COORD_W:0]   EDGE       = (COORD_W + 1)'(SIZE);

  logic [15:0]            lfsr_s;
  logic                   unused_lfsr_s;
  logic                   tick_s;
  logic [2:0]             eff_s;
  logic [CNT_W-1:0]       spawn_cnt_r;
  logic [NUM_METEORS-1:0] idle_s;
  logic [NUM_METEORS-1:0] spawn_sel_s;
  logic [NUM_METEORS-1:0] exit_s;
  logic [NUM_METEORS-1:0] cover_s;
  logic                   spawn_now_s;
  logic [COORD_W-1:0]     fold_a_s;
  logic [COORD_W-1:0]     fold_b_s;
  logic [COORD_W-1:0]     spawn_x_s;
  logic [COORD_W:0]       h_w_s;
  logic [COORD_W:0]       v_w_s;
  logic [7:0]             exit_num_s;
  logic [8:0]             dodge_sum_s;
  logic                   player_d_r;

  lfsr16 u_lfsr (
    .clock (clock),
    .reset (reset),
    .value (lfsr_s)
  );

  // Only the low COORD_W bits seed the spawn column.
  assign unused_lfsr_s = ^lfsr_s[15:COORD_W];

  assign tick_s      = frame_tick & enable;
  assign eff_s       = eff_speed(speed);
  assign h_w_s       = {1'b0, h_count};
  assign v_w_s       = {1'b0, v_count};
  // Isolate the lowest set bit: lowest-index IDLE meteor gets the spawn.
  assign spawn_sel_s = idle_s & (~idle_s + NUM_METEORS'(1));
  assign spawn_now_s = tick_s && (spawn_cnt_r == {CNT_W{1'b0}}) && (|idle_s);

  // Fold the raw LFSR column into [0, H_ACTIVE-SIZE) with at most two subtracts
  always_comb begin
    fold_a_s = lfsr_s[COORD_W-1:0];
    if (fold_a_s >= X_SPAN) begin
      fold_b_s = fold_a_s - X_SPAN;
    end else begin
      fold_b_s = fold_a_s;
    end
    if (fold_b_s >= X_SPAN) begin
      spawn_x_s = fold_b_s - X_SPAN;
    end else begin
      spawn_x_s = fold_b_s;
    end
  end

  for (genvar g = 0; g < NUM_METEORS; g++) begin : g_met
    logic [0:0]         state_r;
    logic [COORD_W-1:0] x_r;
    logic [COORD_W-1:0] y_r;
    logic [COORD_W:0]   y_next_s;

    // One extra bit so y + speed cannot wrap before the exit compare.
    assign y_next_s   = {1'b0, y_r} + (COORD_W + 1)'(eff_s);
    assign idle_s[g]  = (state_r == ST_IDLE);
    assign exit_s[g]  = tick_s && (state_r == ST_FALL) && (y_next_s >= Y_LIMIT);
    assign cover_s[g] = (state_r == ST_FALL)
                     && (h_w_s >= {1'b0, x_r}) && (h_w_s < ({1'b0, x_r} + EDGE))
                     && (v_w_s >= {1'b0, y_r}) && (v_w_s < ({1'b0, y_r} + EDGE));

    // Per-meteor state: spawn from IDLE, fall and exit from FALL
    always_ff @(posedge clock) begin
      if (reset) begin
        state_r <= ST_IDLE;
        x_r     <= {COORD_W{1'b0}};
        y_r     <= {COORD_W{1'b0}};
      end else if (tick_s) begin
        case (state_r)
          ST_IDLE: begin
            if (spawn_now_s && spawn_sel_s[g]) begin
              state_r <= ST_FALL;
              x_r     <= spawn_x_s;
              y_r     <= {COORD_W{1'b0}};
            end
          end
          ST_FALL: begin
            if (y_next_s >= Y_LIMIT) begin
              state_r <= ST_IDLE;
              y_r     <= {COORD_W{1'b0}};
            end else begin
              y_r <= y_next_s[COORD_W-1:0];
            end
          end
          default: begin
            state_r <= ST_IDLE;
            y_r     <= {COORD_W{1'b0}};
          end
        endcase
      end
    end
  end

  // Spawn interval counter; parks at zero while every slot is busy
  always_ff @(posedge clock) begin
    if (reset) begin
      spawn_cnt_r <= GAP_RELOAD;
    end else if (tick_s) begin
      if (spawn_cnt_r == {CNT_W{1'b0}}) begin
        if (|idle_s) begin
          spawn_cnt_r <= GAP_RELOAD;
        end
      end else begin
        spawn_cnt_r <= spawn_cnt_r - CNT_W'(1);
      end
    end
  end

  // Number of meteors leaving the bottom edge this frame
  always_comb begin
    exit_num_s = 8'd0;
    for (int i = 0; i < NUM_METEORS; i++) begin
      exit_num_s = exit_num_s + {7'd0, exit_s[i]};
    end
  end

  assign dodge_sum_s = {1'b0, dodge_count} + {1'b0, exit_num_s};

  // Dodge pulse and saturating dodge counter
  always_ff @(posedge clock) begin
    if (reset) begin
      dodged      <= 1'b0;
      dodge_count <= 8'd0;
    end else begin
      dodged <= |exit_s;
      if (|exit_s) begin
        dodge_count <= dodge_sum_s[8] ? 8'hFF : dodge_sum_s[7:0];
      end
    end
  end

  // Registered meteor mask plus player_on delayed to line up with it
  always_ff @(posedge clock) begin
    if (reset) begin
      meteor_on  <= 1'b0;
      player_d_r <= 1'b0;
    end else begin
      meteor_on  <= |cover_s;
      player_d_r <= player_on;
    end
  end

  // Sticky hit flag; a new collision outranks a same-cycle clear
  always_ff @(posedge clock) begin
    if (reset) begin
      hit <= 1'b0;
    end else if (meteor_on && player_d_r) begin
      hit <= 1'b1;
    end else if (hit_clear) begin
      hit <= 1'b0;
    end
  end

endmodule
